writeback_queue: RTL and testbench

WRITEBACK_QUEUE -- requirements
Module: writeback_queue

---
 rtl/writeback_queue.sv | 154 +++++++++++++++
 tb/tb_writeback_queue.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/writeback_queue.sv
// Multi-channel writeback queue: a round-robin arbiter feeds an in-order FIFO that drains into the register file.
// Optional store-to-read forwarding of queued values is enabled by defining WB_QUEUE_FWD_EN.
module writeback_queue #(
  parameter int XLEN  = 64,
  parameter int N_CH  = 2,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [N_CH-1:0]              in_valid,
  output logic [N_CH-1:0]              in_ready,
  input  logic [N_CH*XLEN-1:0]         in_alu,
  input  logic [N_CH*XLEN-1:0]         in_mem,
  input  logic [N_CH-1:0]              in_memtoreg,
  input  logic [N_CH*5-1:0]            in_rd,
  input  logic                         rf_ready,
  output logic                         rf_we,
  output logic [4:0]                   rf_waddr,
  output logic [XLEN-1:0]              rf_wdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  input  logic [4:0]                   fwd_rs,
  output logic                         fwd_hit,
  output logic [XLEN-1:0]              fwd_data
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam int RW = $clog2(N_CH);

  logic [PW-1:0]   head_reg;
  logic [PW-1:0]   tail_reg;
  logic [CW-1:0]   count_reg;
  logic [RW-1:0]   rr_reg;
  logic [DEPTH-1:0] entry_valid_reg;

  logic [4:0]      entry_rd  [DEPTH];
  logic [XLEN-1:0] entry_val [DEPTH];

  logic [XLEN-1:0] ch_value [N_CH];
  logic [4:0]      ch_rd    [N_CH];

  logic            grant_found;
  logic [RW-1:0]   grant_idx;
  logic [RW-1:0]   rr_next;
  logic [XLEN-1:0] sel_value;
  logic [4:0]      sel_rd;
  logic            accept;
  logic            push;
  logic            pop;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign ch_value[gi] = in_memtoreg[gi] ? in_mem[gi*XLEN +: XLEN] : in_alu[gi*XLEN +: XLEN];
      assign ch_rd[gi]    = in_rd[gi*5 +: 5];
    end
  endgenerate

  // Search starts at rr and wraps, so the first valid channel found is the round-robin winner.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < N_CH; k++) begin
      idx = int'(rr_reg) + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!grant_found && in_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = RW'(idx);
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (grant_found && !full && rst_n) in_ready[grant_idx] = 1'b1;
  end

  assign sel_value = ch_value[grant_idx];
  assign sel_rd    = ch_rd[grant_idx];
  assign accept    = |(in_valid & in_ready);
  // Writes to x0 complete the handshake but never occupy a slot.
  assign push      = accept && (sel_rd != 5'd0);
  assign pop       = rf_we && rf_ready;
  assign rr_next   = (grant_idx == RW'(N_CH-1)) ? '0 : grant_idx + RW'(1);

  assign count    = count_reg;
  assign full     = (count_reg == CW'(DEPTH));
  assign empty    = (count_reg == '0);
  assign rf_we    = !empty;
  assign rf_waddr = empty ? 5'd0 : entry_rd[head_reg];
  assign rf_wdata = empty ? '0 : entry_val[head_reg];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_reg        <= '0;
      tail_reg        <= '0;
      count_reg       <= '0;
      rr_reg          <= '0;
      entry_valid_reg <= '0;
    end else begin
      if (accept) rr_reg <= rr_next;
      if (pop) begin
        head_reg                  <= head_reg + PW'(1);
        entry_valid_reg[head_reg] <= 1'b0;
      end
      if (push) begin
        tail_reg                  <= tail_reg + PW'(1);
        entry_valid_reg[tail_reg] <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy is tracked by count and the valid bits.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_rd[tail_reg]  <= sel_rd;
      entry_val[tail_reg] <= sel_value;
    end
  end

`ifdef WB_QUEUE_FWD_EN
  // Scan oldest to youngest so the last match wins.
  always_comb begin
    logic [PW-1:0] slot;
    slot     = '0;
    fwd_hit  = 1'b0;
    fwd_data = '0;
    if (fwd_rs != 5'd0) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot = head_reg + PW'(k);
        if (entry_valid_reg[slot] && (entry_rd[slot] == fwd_rs)) begin
          fwd_hit  = 1'b1;
          fwd_data = entry_val[slot];
        end
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_rs, entry_valid_reg};
  assign fwd_hit    = 1'b0;
  assign fwd_data   = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Directed self-checking bench for writeback_queue with default parameters.
module tb_writeback_queue;
  localparam int XLEN  = 64;
  localparam int N_CH  = 2;
  localparam int DEPTH = 4;

  logic                       clk;
  logic                       rst_n;
  logic [N_CH-1:0]            in_valid;
  logic [N_CH-1:0]            in_ready;
  logic [N_CH*XLEN-1:0]       in_alu;
  logic [N_CH*XLEN-1:0]       in_mem;
  logic [N_CH-1:0]            in_memtoreg;
  logic [N_CH*5-1:0]          in_rd;
  logic                       rf_ready;
  logic                       rf_we;
  logic [4:0]                 rf_waddr;
  logic [XLEN-1:0]            rf_wdata;
  logic [$clog2(DEPTH+1)-1:0] count;
  logic                       full;
  logic                       empty;
  logic [4:0]                 fwd_rs;
  logic                       fwd_hit;
  logic [XLEN-1:0]            fwd_data;

  int checks = 0;
  int errors = 0;

  writeback_queue #(.XLEN(XLEN), .N_CH(N_CH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu(in_alu), .in_mem(in_mem), .in_memtoreg(in_memtoreg), .in_rd(in_rd),
    .rf_ready(rf_ready), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .count(count), .full(full), .empty(empty),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic v, input logic [4:0] rd,
                        input logic [63:0] alu, input logic [63:0] mem, input logic m2r);
    in_valid[ch]          = v;
    in_rd[ch*5 +: 5]      = rd;
    in_alu[ch*XLEN +: XLEN] = alu;
    in_mem[ch*XLEN +: XLEN] = mem;
    in_memtoreg[ch]       = m2r;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = '0; in_alu = '0; in_mem = '0; in_memtoreg = '0;
    in_rd = '0; rf_ready = 1'b0; fwd_rs = 5'd0;

    // Reset state, with a request held during reset
    @(negedge clk); @(negedge clk);
    set_ch(0, 1'b1, 5'd5, 64'h55, 64'h0, 1'b0);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_fwd_hit", fwd_hit, 0);
    chk("rst_fwd_data", fwd_data, 0);
    @(negedge clk);
    chk("rst_count", count, 0);
    set_ch(0, 1'b0, 5'd0, 64'h0, 64'h0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_empty", empty, 1);

    // Single write, ALU select
    set_ch(0, 1'b1, 5'd5, 64'h1234, 64'h0, 1'b0);
    rf_ready = 1'b1;
    #1;
    chk("single_in_ready", in_ready, 2'b01);
    @(negedge clk);
    set_ch(0, 1'b0, 5'd0, 64'h0, 64'h0, 1'b0);
    #1;
    chk("single_we", rf_we, 1);
    chk("single_waddr", rf_waddr, 5);
    chk("single_wdata", rf_wdata, 64'h1234);
    @(negedge clk);
    chk("single_empty", empty, 1);

    // Memory select on channel 1
    set_ch(1, 1'b1, 5'd7, 64'h1, 64'hDEAD_BEEF, 1'b1);
    #1;
    chk("mem_in_ready", in_ready, 2'b10);
    @(negedge clk);
    set_ch(1, 1'b0, 5'd0, 64'h0, 64'h0, 1'b0);
    #1;
    chk("mem_waddr", rf_waddr, 7);
    chk("mem_wdata", rf_wdata, 64'hDEAD_BEEF);
    @(negedge clk);
    chk("mem_empty", empty, 1);

    // Round-robin with both channels always requesting
    set_ch(0, 1'b1, 5'd1, 64'h10, 64'h0, 1'b0);
    set_ch(1, 1'b1, 5'd2, 64'h20, 64'h0, 1'b0);
    #1;
    chk("rr_ready0", in_ready, 2'b01);
    @(negedge clk); #1;
    chk("rr_ready1", in_ready, 2'b10);
    chk("rr_waddr0", rf_waddr, 1);
    @(negedge clk); #1;
    chk("rr_ready2", in_ready, 2'b01);
    chk("rr_waddr1", rf_waddr, 2);
    chk("rr_count", count, 1);
    @(negedge clk); #1;
    chk("rr_ready3", in_ready, 2'b10);
    chk("rr_waddr2", rf_waddr, 1);
    @(negedge clk);
    set_ch(0, 1'b0, 5'd0, 64'h0, 64'h0, 1'b0);
    set_ch(1, 1'b0, 5'd0, 64'h0, 64'h0, 1'b0);
    #1;
    chk("rr_waddr3", rf_waddr, 2);
    chk("rr_wdata3", rf_wdata, 64'h20);
    @(negedge clk);
    chk("rr_empty", empty, 1);

    // Fill under backpressure, then drain in order (pointers wrap here)
    rf_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      set_ch(0, 1'b1, 5'(i), 64'(i * 16), 64'h0, 1'b0);
      #1;
      chk("fill_ready", in_ready, 2'b01);
      @(negedge clk);
    end
    set_ch(0, 1'b1, 5'd5, 64'h50, 64'h0, 1'b0);
    #1;
    chk("full_count", count, 4);
    chk("full_flag", full, 1);
    chk("full_in_ready", in_ready, 0);
    @(negedge clk); #1;
    chk("full_hold_count", count, 4);
    chk("full_hold_waddr", rf_waddr, 1);
    set_ch(0, 1'b0, 5'd0, 64'h0, 64'h0, 1'b0);
    rf_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      chk("drain_waddr", rf_waddr, 64'(i));
      chk("drain_wdata", rf_wdata, 64'(i * 16));
      @(negedge clk);
    end
    chk("drain_empty", empty, 1);

    // x0 write is consumed but dropped
    set_ch(0, 1'b1, 5'd0, 64'hFF, 64'h0, 1'b0);
    #1;
    chk("x0_in_ready", in_ready, 2'b01);
    @(negedge clk);
    set_ch(0, 1'b0, 5'd0, 64'h0, 64'h0, 1'b0);
    #1;
    chk("x0_count", count, 0);
    chk("x0_rf_we", rf_we, 0);

    // Forwarding lookup and mid-run reset
    rf_ready = 1'b0;
    set_ch(0, 1'b1, 5'd3, 64'hA, 64'h0, 1'b0);
    @(negedge clk);
    set_ch(0, 1'b1, 5'd3, 64'hB, 64'h0, 1'b0);
    @(negedge clk);
    set_ch(0, 1'b0, 5'd0, 64'h0, 64'h0, 1'b0);
    fwd_rs = 5'd3;
    #1;
    chk("fwd_count", count, 2);
    chk("fwd_head", rf_wdata, 64'hA);
`ifdef WB_QUEUE_FWD_EN
    chk("fwd_hit", fwd_hit, 1);
    chk("fwd_data", fwd_data, 64'hB);
`else
    chk("fwd_hit_off", fwd_hit, 0);
    chk("fwd_data_off", fwd_data, 0);
`endif
    fwd_rs = 5'd0;
    #1;
    chk("fwd_x0_hit", fwd_hit, 0);
    fwd_rs = 5'd3;
    @(negedge clk);
    rst_n = 1'b0;
    set_ch(1, 1'b1, 5'd9, 64'h99, 64'h0, 1'b0);
    #1;
    chk("midrst_in_ready", in_ready, 0);
    @(negedge clk); #1;
    chk("midrst_count", count, 0);
    chk("midrst_rf_we", rf_we, 0);
    chk("midrst_fwd_hit", fwd_hit, 0);
    rst_n = 1'b1;
    set_ch(1, 1'b0, 5'd0, 64'h0, 64'h0, 1'b0);
    @(negedge clk);
    chk("midrst_empty", empty, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
